// File: rtl/prbs_chk_pkg.sv
// Shared types and polynomial tap constants for the PRBS receive checkers.
package prbs_chk_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } prbs_chk_state_t;

    // Taps for x^A + x^B + 1 polynomials
    localparam int PRBS7_TAP_A  = 7;
    localparam int PRBS7_TAP_B  = 6;
    localparam int PRBS15_TAP_A = 15;
    localparam int PRBS15_TAP_B = 14;
    localparam int PRBS21_TAP_A = 21;
    localparam int PRBS21_TAP_B = 19;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

endpackage

// File: rtl/prbs21_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (!rstb || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/prbs21_checker.sv
// Self-synchronising PRBS checker: seeds from the line, verifies, then free-runs and counts bit errors.
module prbs21_checker
    import prbs_chk_pkg::*;
#(
    parameter int TAP_A       = PRBS21_TAP_A,
    parameter int TAP_B       = PRBS21_TAP_B,
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 1024,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 64
) (
    input  logic             clk_i,
    input  logic             rstb,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             clr_i,
    output logic [1:0]       state_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] total_bits_o,
    output logic [CNT_W-1:0] err_bits_o
);

    localparam int SEED_W  = $clog2(TAP_A + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

    prbs_chk_state_t    state, state_nx;
    logic [TAP_A-1:0]   s, s_nx;
    logic [SEED_W-1:0]  seed_cnt, seed_nx;
    logic [MATCH_W-1:0] match_cnt, match_nx;
    logic [WIN_W-1:0]   win_cnt, win_nx;
    logic [WERR_W-1:0]  win_errs, werr_nx, werr_sum;
    logic               pred, mism, err_nx, total_inc, err_inc;

    assign pred     = s[TAP_A-1] ^ s[TAP_B-1];
    assign mism     = pred ^ data_i;
    assign werr_sum = win_errs + WERR_W'(mism);

    always_comb begin
        state_nx  = state;
        s_nx      = s;
        seed_nx   = seed_cnt;
        match_nx  = match_cnt;
        win_nx    = win_cnt;
        werr_nx   = win_errs;
        err_nx    = 1'b0;
        total_inc = 1'b0;
        err_inc   = 1'b0;
        if (valid_i) begin
            unique case (state)
                SEED: begin
                    s_nx = {s[TAP_A-2:0], data_i};
                    if (seed_cnt == SEED_W'(TAP_A - 1)) begin
                        state_nx = VERIFY;
                        match_nx = '0;
                    end else begin
                        seed_nx = seed_cnt + SEED_W'(1);
                    end
                end
                VERIFY: begin
                    s_nx = {s[TAP_A-2:0], data_i};
                    // An all-zero register is the LFSR lockup state and can never be a valid seed
                    if ((s == '0) || mism) begin
                        state_nx = SEED;
                        seed_nx  = '0;
                    end else if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_nx = LOCK;
                        win_nx   = '0;
                        werr_nx  = '0;
                    end else begin
                        match_nx = match_cnt + MATCH_W'(1);
                    end
                end
                LOCK: begin
                    // Feed back the prediction so a line error cannot corrupt later predictions
                    s_nx      = {s[TAP_A-2:0], pred};
                    total_inc = 1'b1;
                    err_inc   = mism;
                    err_nx    = mism;
                    if (werr_sum >= WERR_W'(UNLOCK_ERRS)) begin
                        state_nx = SEED;
                        seed_nx  = '0;
                    end
                    if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        win_nx  = '0;
                        werr_nx = '0;
                    end else begin
                        win_nx  = win_cnt + WIN_W'(1);
                        werr_nx = werr_sum;
                    end
                end
                default: begin
                    state_nx = SEED;
                    seed_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstb) begin
            state     <= SEED;
            s         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_errs  <= '0;
            err_o     <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            state     <= state_nx;
            s         <= s_nx;
            seed_cnt  <= seed_nx;
            match_cnt <= match_nx;
            win_cnt   <= win_nx;
            win_errs  <= werr_nx;
            err_o     <= err_nx;
            locked_o  <= (state_nx == LOCK);
        end
    end

    assign state_o = state;

    sat_counter #(.W(CNT_W)) u_total_cnt (
        .clk   (clk_i),
        .rstb  (rstb),
        .clr   (clr_i),
        .inc   (total_inc),
        .count (total_bits_o)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk_i),
        .rstb  (rstb),
        .clr   (clr_i),
        .inc   (err_inc),
        .count (err_bits_o)
    );

endmodule

// File: tb/tb_prbs21_checker.sv
// Bench for prbs21_checker: PRBS21 generator drives a full-width DUT and a 4-bit-counter twin for saturation.
module tb_prbs21_checker;
    import prbs_chk_pkg::*;

    localparam int SMALL_W = 4;

    logic               clk_i = 1'b0;
    logic               rstb = 1'b0;
    logic               data_i = 1'b0;
    logic               valid_i = 1'b0;
    logic               clr_i = 1'b0;
    logic [1:0]         state_o, state_s;
    logic               locked_o, locked_s, err_o, err_s;
    logic [63:0]        total_bits_o, err_bits_o;
    logic [SMALL_W-1:0] total_s, errs_s;

    prbs21_checker dut (
        .clk_i        (clk_i),
        .rstb         (rstb),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .clr_i        (clr_i),
        .state_o      (state_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .total_bits_o (total_bits_o),
        .err_bits_o   (err_bits_o)
    );

    prbs21_checker #(.CNT_W(SMALL_W)) dut_small (
        .clk_i        (clk_i),
        .rstb         (rstb),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .clr_i        (clr_i),
        .state_o      (state_s),
        .locked_o     (locked_s),
        .err_o        (err_s),
        .total_bits_o (total_s),
        .err_bits_o   (errs_s)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        bit          chk_state;
        logic [1:0]  state;
        bit          chk_err;
        logic        err;
        bit          chk_cnt;
        logic [63:0] total;
        logic [63:0] errs;
    } exp_t;

    typedef struct {
        logic        rstb;
        logic        valid;
        logic        data;
        logic        clr;
        logic [1:0]  state;
        logic        err;
        logic [63:0] total;
        logic [63:0] errs;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[60];
    int          checks = 0;
    int          errors = 0;
    logic [20:0] gen;
    logic [63:0] exp_total, exp_errs;

    function automatic logic [63:0] sat4(input logic [63:0] x);
        return (x > 64'd15) ? 64'd15 : x;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic expectNext(input string name, input bit cs, input logic [1:0] st,
                              input bit ce, input logic er, input bit cc,
                              input logic [63:0] tot, input logic [63:0] eb);
        exp_t e;
        e.name = name; e.chk_state = cs; e.state = st; e.chk_err = ce; e.err = er;
        e.chk_cnt = cc; e.total = tot; e.errs = eb;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        if (e.chk_state) begin
            cmp({e.name, ".state"}, 64'(state_o), 64'(e.state));
            cmp({e.name, ".locked"}, 64'(locked_o), 64'(e.state == 2'd2));
            cmp({e.name, ".small_state"}, 64'(state_s), 64'(e.state));
        end
        if (e.chk_err) begin
            cmp({e.name, ".err"}, 64'(err_o), 64'(e.err));
            cmp({e.name, ".small_err"}, 64'(err_s), 64'(e.err));
        end
        if (e.chk_cnt) begin
            cmp({e.name, ".total"}, total_bits_o, e.total);
            cmp({e.name, ".errs"}, err_bits_o, e.errs);
            cmp({e.name, ".small_total"}, 64'(total_s), sat4(e.total));
            cmp({e.name, ".small_errs"}, 64'(errs_s), sat4(e.errs));
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic d, input logic c);
        @(negedge clk_i);
        rstb = r; valid_i = v; data_i = d; clr_i = c;
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    task automatic sendGen(input bit flip, input bit clr);
        logic b;
        b   = gen[20] ^ gen[18];
        gen = {gen[19:0], b};
        applyStimulus(1'b1, 1'b1, b ^ flip, clr);
    endtask

    // Reset, then seed/verify a fresh lock in exactly 21+32 bits
    task automatic acquireLock(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 53; i++) begin
            if (i == 20 || i == 21 || i == 52 || i == 53)
                expectNext($sformatf("%s_acq%0d", tag, i), 1, (i < 21) ? 2'd0 : (i < 53) ? 2'd1 : 2'd2,
                           1, 1'b0, 1, 64'd0, 64'd0);
            sendGen(0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int pos;

        // Constant-zero stream with a few idle cycles: must bounce SEED->VERIFY->SEED forever
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0};
        k = 0;
        for (int i = 1; i < 60; i++) begin
            vecs[i].rstb  = 1'b1;
            vecs[i].valid = !(i == 7 || i == 23 || i == 24 || i == 40);
            vecs[i].data  = 1'b0;
            vecs[i].clr   = (i == 30);
            if (vecs[i].valid) k++;
            vecs[i].state = (k > 0 && (k % 22) == 21) ? 2'd1 : 2'd0;
            vecs[i].err   = 1'b0;
            vecs[i].total = 64'd0;
            vecs[i].errs  = 64'd0;
        end
        for (int i = 0; i < 60; i++) begin
            expectNext($sformatf("zeros%0d", i), 1, vecs[i].state, 1, vecs[i].err, 1,
                       vecs[i].total, vecs[i].errs);
            applyStimulus(vecs[i].rstb, vecs[i].valid, vecs[i].data, vecs[i].clr);
        end

        // Clean lock from an arbitrary generator phase, then 1000 counted bits
        gen = 21'($urandom_range(1, (1 << 21) - 1));
        acquireLock("t1");
        for (int i = 1; i <= 1000; i++) begin
            if (i % 250 == 0)
                expectNext($sformatf("t1_run%0d", i), 1, 2'd2, 1, 1'b0, 1, 64'(i), 64'd0);
            sendGen(0, 0);
        end
        exp_total = 64'd1000;

        // Single flipped bit: one err pulse, no propagation
        exp_total++;
        expectNext("t2_flip", 1, 2'd2, 1, 1'b1, 1, exp_total, 64'd1);
        sendGen(1, 0);
        for (int j = 1; j <= 5; j++) begin
            exp_total++;
            expectNext($sformatf("t2_after%0d", j), 1, 2'd2, 1, 1'b0, 1, exp_total, 64'd1);
            sendGen(0, 0);
        end

        // Clear beats a counted bit; err_o still reports the bit
        expectNext("t6_clr", 1, 2'd2, 1, 1'b0, 1, 64'd0, 64'd0);
        sendGen(0, 1);
        expectNext("t6_clr_flip", 1, 2'd2, 1, 1'b1, 1, 64'd0, 64'd0);
        sendGen(1, 1);
        expectNext("t6_post_clr", 1, 2'd2, 1, 1'b0, 1, 64'd1, 64'd0);
        sendGen(0, 0);
        for (int j = 0; j < 10; j++) begin
            expectNext($sformatf("t6_idle%0d", j), 1, 2'd2, 1, 1'b0, 1, 64'd1, 64'd0);
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        expectNext("t6_resume", 1, 2'd2, 1, 1'b0, 1, 64'd2, 64'd0);
        sendGen(0, 0);
        expectNext("t6_flip2", 1, 2'd2, 1, 1'b1, 1, 64'd3, 64'd1);
        sendGen(1, 0);
        expectNext("t6_reset", 1, 2'd0, 1, 1'b0, 1, 64'd0, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        // Eight errors inside one window force relock
        acquireLock("t3");
        for (int i = 0; i < 100; i++) sendGen(0, 0);
        exp_total = 64'd100;
        for (int f = 1; f <= 8; f++) begin
            exp_total++;
            expectNext($sformatf("t3_err%0d", f), 1, (f < 8) ? 2'd2 : 2'd0, 1, 1'b1, 1,
                       exp_total, 64'(f));
            sendGen(1, 0);
            if (f < 8) begin
                for (int j = 0; j < 3; j++) begin
                    exp_total++;
                    expectNext($sformatf("t3_gap%0d_%0d", f, j), 1, 2'd2, 1, 1'b0, 0, 64'd0, 64'd0);
                    sendGen(0, 0);
                end
            end
        end
        for (int i = 1; i <= 53; i++) begin
            if (i == 21 || i == 52 || i == 53)
                expectNext($sformatf("t3_relock%0d", i), 1, (i < 53) ? 2'd1 : 2'd2, 1, 1'b0, 1,
                           exp_total, 64'd8);
            sendGen(0, 0);
        end

        // Seven errors at the end of window 1 and seven at the start of window 2 must not unlock
        acquireLock("t4");
        exp_errs = 64'd0;
        for (pos = 1; pos <= 2060; pos++) begin
            bit flip;
            flip = (pos >= 1018 && pos <= 1031) || pos == 2050 || pos == 2051;
            if (flip) exp_errs++;
            if (flip || pos == 1032 || pos == 2048 || pos == 2060)
                expectNext($sformatf("t4_pos%0d", pos), 1, 2'd2, 1, 1'(flip), 1, 64'(pos), exp_errs);
            sendGen(flip, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
